// File: rtl/acc_pkg.sv
// Shared accumulator-path constants and the store-buffer handshake state encoding.
// Imported by the accumulator, ALU and store buffer so their widths stay consistent.
package acc_pkg;

   localparam int ACC_W      = 16;
   localparam int MEM_ADDR_W = 10;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } sb_state_t;

endpackage

// File: rtl/acc_fifo.sv
// Synchronous FIFO of DEPTH entries holding pending (address, data) store pairs.
// Head entry is presented combinationally on rdata; pointers wrap modulo DEPTH.
module acc_fifo
   import acc_pkg::*;
#(
   parameter int WIDTH = ACC_W + MEM_ADDR_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Guard against illegal push/pop so the pointers can never overrun.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; validity is defined
   // entirely by the pointers and count, and an unreset array maps to plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/acc_store_buffer.sv
// Accumulator store buffer: queues STA (address, acc) pairs and drains them to
// data memory through a registered req/ack handshake, strictly in FIFO order.
module acc_store_buffer
   import acc_pkg::*;
#(
   parameter int DATA_W = ACC_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   st_valid,
   output logic                   st_ready,
   input  logic [ADDR_W-1:0]      st_addr,
   input  logic [DATA_W-1:0]      acc,
   output logic                   mem_req,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic                   mem_ack,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   err_spurious_ack
);

   localparam int ENTRY_W = ADDR_W + DATA_W;

   sb_state_t          state;
   sb_state_t          next_state;
   logic               push;
   logic               pop;
   logic               load;
   logic               full;
   logic               empty;
   logic [ENTRY_W-1:0] head;

   // No bypass: a pop in the same cycle does not open a slot while full.
   assign st_ready = !full;
   assign push     = st_valid && st_ready;
   assign busy     = !empty || (state != IDLE);

   acc_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({st_addr, acc}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               next_state = REQ;
               load       = 1'b1;
            end
         end
         REQ: begin
            if (mem_ack) begin
               next_state = IDLE;
               pop        = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Address and data are captured once on entry to REQ and held until the ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (load) begin
         mem_req   <= 1'b1;
         mem_addr  <= head[ENTRY_W-1 -: ADDR_W];
         mem_wdata <= head[DATA_W-1:0];
      end else if (pop) begin
         mem_req   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     err_spurious_ack <= 1'b0;
      else if (mem_ack && !mem_req) err_spurious_ack <= 1'b1;
   end

endmodule

// File: doc/acc_store_buffer.md
Name: acc_store_buffer

Overview:
- Consumer side of the accumulator: takes the current accumulator value on a store (STA) request and writes it to data memory over a req/ack handshake.
- Buffers up to DEPTH pending (address, data) pairs so the control unit does not stall on slow memory.
- Sits between the accumulator/control unit and the data-memory write port.

Parameters:
- DATA_W, 16, width of the accumulator and of the memory write data.
- ADDR_W, 10, width of the data-memory address.
- DEPTH, 4, number of buffered store entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- st_valid  input  1  control unit requests a store this cycle.
- st_ready  output  1  buffer can accept a store; equals !full.
- st_addr  input  ADDR_W  destination address for the store.
- acc  input  DATA_W  accumulator value, captured together with st_addr.
- mem_req  output  1  write request to memory; registered.
- mem_addr  output  ADDR_W  head entry address; valid while mem_req=1.
- mem_wdata  output  DATA_W  head entry data; valid while mem_req=1.
- mem_ack  input  1  memory has completed the write.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- busy  output  1  asserted when count!=0 or the FSM is not IDLE.
- err_spurious_ack  output  1  sticky flag: mem_ack was seen while mem_req=0.

Behaviour:
- Reset: while rst=0, all of the following are forced immediately, independent of clk:
  - count=0, read/write pointers=0, FSM=IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, err_spurious_ack=0.
  - st_ready=1 once reset has cleared the buffer.
- Reset mid-transaction: the outstanding write is abandoned and mem_req drops asynchronously. Memory must tolerate an aborted request.
- Enqueue: a store is accepted at a rising edge where st_valid=1 and st_ready=1. {st_addr, acc} is written at the write pointer.
  - A store while full is not accepted; the control unit holds st_valid. This is not an error.
- Full with a pop in the same cycle: st_ready is still 0, so there is no bypass.
- Pointers wrap modulo DEPTH.
- Count update: +1 on enqueue only, -1 on pop only, unchanged when both happen in the same cycle.
- FSM states: IDLE and REQ.
  - IDLE: if count!=0, go to REQ at the next edge. mem_req, mem_addr and mem_wdata are registered from the head entry at that same edge.
  - REQ: mem_req=1, and mem_addr/mem_wdata are held stable. At an edge with mem_ack=1, pop the head, clear mem_req, and return to IDLE.
- Latency:
  - Store accepted at edge E into an empty buffer gives mem_req=1 from edge E+1.
  - Minimum ack-to-next-req spacing is 1 idle cycle, so back-to-back writes take 2 cycles each with zero-wait memory.
- Write order is strictly FIFO.
- Spurious ack: mem_ack=1 at an edge where mem_req=0 sets err_spurious_ack. The flag is cleared only by reset and has no other effect.
- No data transformation: acc passes through unchanged at DATA_W width.

Decomposition:
- Shared package acc_pkg holds:
  - ACC_W=16 and MEM_ADDR_W=10 constants, reused by the accumulator and ALU.
  - FSM state encoding: IDLE=1'b0, REQ=1'b1.
- One sub-module, acc_fifo: synchronous DEPTH x (ADDR_W+DATA_W) FIFO with push, pop, full, empty and count, using the same async active-low rst.
- acc_store_buffer contains only the handshake FSM, the output registers and the error flag.

Test Plan:
- Reset: hold rst=0 for 25 time units with st_valid=1 -> count=0, mem_req=0, st_ready=1. No enqueue until rst=1.
- Single store: acc=16'h0002, st_addr=10'h005, accepted at edge E, mem_ack pulsed 3 cycles after req rises -> mem_req=1 from E+1, mem_addr=005 and mem_wdata=0002 held stable for 3 cycles, count goes 1 -> 0 after the ack edge.
- Fill and ordering: 5 consecutive stores (acc=1..5, addr=0..4) with mem_ack=0 -> first 4 accepted, st_ready=0 on the 5th. Then mem_ack=1 permanently -> writes appear in order 1,2,3,4 with one idle cycle between mem_req pulses, and the 5th is accepted after the first pop.
- Simultaneous push/pop: count=2, st_valid=1 and mem_ack=1 in the same cycle -> count stays 2 and the head advances.
- Reset mid-write: mem_req=1 with 3 entries queued, drive rst=0 between edges -> mem_req=0 immediately, count=0, and no write is issued after release.
- Spurious ack: mem_ack=1 while idle -> err_spurious_ack=1 and stays 1 through later normal writes until reset.
